ext_arbiter: RTL
================

Name: ext_arbiter

Overview:
- Shares one 16→32 immediate extension unit between two requesters: port A (decode stage, immediate operands) and port B (branch unit, branch offsets).
- Arbitrates requests each cycle, with round-robin priority on conflict.
- Computes the extension per the 2-bit EOp code.
- Holds the result in a one-entry output buffer with valid/ready handshake and source tag.

Parameters:
CNT_W, 16, width of per-requester grant counters (used only with EXT_STATS_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_a  in  1  requester A request; held high until gnt_a
imm_a  in  16  requester A immediate
eop_a  in  2  requester A extension op
req_b  in  1  requester B request; held high until gnt_b
imm_b  in  16  requester B immediate
eop_b  in  2  requester B extension op
gnt_a  out  1  one-cycle pulse: A's operands captured this edge
gnt_b  out  1  one-cycle pulse: B's operands captured this edge
out_valid  out  1  result buffer holds a valid result
out_ready  in  1  consumer accepts result when out_valid && out_ready
out_tag  out  1  0 = result belongs to A, 1 = result belongs to B
out_ext  out  32  extended immediate
cnt_a  out  CNT_W  grants issued to A (EXT_STATS_EN only)
cnt_b  out  CNT_W  grants issued to B (EXT_STATS_EN only)

Behaviour:
- EOp encoding, computed combinationally on the selected operand before the buffer:
  - 00: sign-extend, {{16{imm[15]}},imm}
  - 01: zero-extend, {16'h0,imm}
  - 10: load-upper, {imm,16'h0}
  - 11: sign-extend then shift left 2, {{14{imm[15]}},imm,2'b00}
- Buffer free condition: free = !out_valid || out_ready. Grants are issued only when free.
- gnt_a/gnt_b are combinational:
  - Only one requester asserting: it is granted.
  - Both asserting: the side indicated by priority pointer prio is granted (0 = A, 1 = B).
  - Never both high in the same cycle.
- On a grant edge:
  - out_ext ← ext(selected imm, eop), out_tag ← selected side, out_valid ← 1.
  - prio ← opposite of granted side.
  - prio changes only on a grant.
- Latency: request at cycle n with buffer free → gnt in cycle n → out_valid/out_ext visible in cycle n+1.
- Drain without a new grant: out_valid ← 0 on the edge where out_valid && out_ready.
- Simultaneous drain and grant in the same cycle: the buffer is overwritten with the new result and out_valid stays 1. This gives full throughput of one result per cycle.
- Stall: while out_valid && !out_ready:
  - No grant is issued.
  - out_ext/out_tag/out_valid hold stable.
  - Requesters keep req high.
- Requesters must not change imm/eop while req is high and gnt is low.
- Reset:
  - out_valid=0, out_ext=32'h0, out_tag=0, prio=0 (A favoured).
  - gnt_a=gnt_b=0 during reset regardless of req.
  - Reset mid-transaction discards the buffered result; no grant is issued that cycle.
- No internal FSM beyond prio and out_valid. States are EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY → FULL on a grant.
  - FULL → EMPTY on drain with no grant.
  - FULL → FULL on drain+grant or on stall.

Optional Feature:
- Macro: EXT_STATS_EN.
- Defined:
  - cnt_a/cnt_b increment by 1 on each gnt_a/gnt_b edge.
  - Counters saturate at all-ones, with no wrap.
  - Reset to 0.
- Undefined:
  - cnt_a/cnt_b ports are still present but tied to 0.
  - No counter registers are synthesized.

Test Plan:
- Reset, then req_a=1 alone with imm_a=16'h8001, eop_a=00 → gnt_a=1 in the same cycle; next cycle out_valid=1, out_tag=0, out_ext=32'hFFFF8001.
- req_b alone, imm_b=16'h1234, eop_b=10, out_ready=1 → out_ext=32'h12340000, out_tag=1. Repeat with eop=01, imm=16'hFFFF → 32'h0000FFFF. Repeat with eop=11, imm=16'hFFFE → 32'hFFFFFFF8.
- req_a and req_b held continuously, out_ready=1, from reset → grants alternate A,B,A,B, one per cycle; out_tag sequence 0,1,0,1 with no bubbles.
- Result buffered with out_ready=0 for 3 cycles while req_a=1 → no gnt_a and out_ext stable for 3 cycles. out_ready=1 on cycle 4 → gnt_a in that cycle, new result next cycle, out_valid never drops.
- Assert reset while out_valid=1 and req_b=1 → next cycle out_valid=0, out_ext=0, prio=0. After reset release with both requesting → A granted first.
- With EXT_STATS_EN and CNT_W=2, give A 5 grants → cnt_a reads 1,2,3,3,3. Without the macro → cnt_a=cnt_b=0 throughout.

Source files
------------

// File: rtl/ext_if.sv
// Bus bundle between the two immediate requesters, the consumer and ext_arbiter.
// slave = arbiter view, master = requester/consumer view.
interface ext_if #(
  parameter int unsigned CNT_W = 16
);
  logic             req_a;
  logic [15:0]      imm_a;
  logic [1:0]       eop_a;
  logic             req_b;
  logic [15:0]      imm_b;
  logic [1:0]       eop_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             out_valid;
  logic             out_ready;
  logic             out_tag;
  logic [31:0]      out_ext;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  modport slave (
    input  req_a, imm_a, eop_a, req_b, imm_b, eop_b, out_ready,
    output gnt_a, gnt_b, out_valid, out_tag, out_ext, cnt_a, cnt_b
  );

  modport master (
    output req_a, imm_a, eop_a, req_b, imm_b, eop_b, out_ready,
    input  gnt_a, gnt_b, out_valid, out_tag, out_ext, cnt_a, cnt_b
  );
endinterface

// File: rtl/ext_arbiter.sv
// Two-port round-robin arbiter in front of a shared 16->32 immediate extender
// with a one-entry valid/ready result buffer. Optional grant counters: EXT_STATS_EN.
module ext_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input logic  clk,
  input logic  reset,
  ext_if.slave bus
);
  localparam int unsigned IMM_W = 16;
  localparam int unsigned EXT_W = 32;

  logic             prio_q;
  logic             valid_q;
  logic             tag_q;
  logic [EXT_W-1:0] ext_q;

  logic             free_c;
  logic             gnt_a_c;
  logic             gnt_b_c;
  logic             grant_c;
  logic [IMM_W-1:0] sel_imm_c;
  logic [1:0]       sel_eop_c;
  logic [EXT_W-1:0] ext_c;

  // Grant only into a free buffer; prio breaks ties, reset masks both.
  always_comb begin
    free_c    = !valid_q || bus.out_ready;
    gnt_a_c   = !reset && free_c && bus.req_a && (!bus.req_b || !prio_q);
    gnt_b_c   = !reset && free_c && bus.req_b && (!bus.req_a ||  prio_q);
    grant_c   = gnt_a_c || gnt_b_c;
    sel_imm_c = gnt_b_c ? bus.imm_b : bus.imm_a;
    sel_eop_c = gnt_b_c ? bus.eop_b : bus.eop_a;
  end

  // Shared extension unit.
  always_comb begin
    ext_c = '0;
    case (sel_eop_c)
      2'b00:   ext_c = {{16{sel_imm_c[15]}}, sel_imm_c};
      2'b01:   ext_c = {16'h0, sel_imm_c};
      2'b10:   ext_c = {sel_imm_c, 16'h0};
      default: ext_c = {{14{sel_imm_c[15]}}, sel_imm_c, 2'b00};
    endcase
  end

  // Result buffer: EMPTY/FULL is valid_q; a grant overwrites even while draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= 1'b0;
      ext_q   <= '0;
      prio_q  <= 1'b0;
    end else if (grant_c) begin
      valid_q <= 1'b1;
      tag_q   <= gnt_b_c;
      ext_q   <= ext_c;
      prio_q  <= gnt_a_c;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.gnt_a     = gnt_a_c;
  assign bus.gnt_b     = gnt_b_c;
  assign bus.out_valid = valid_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_ext   = ext_q;

`ifdef EXT_STATS_EN
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;

  // Saturating grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (gnt_a_c && (cnt_a_q != {CNT_W{1'b1}})) cnt_a_q <= cnt_a_q + CNT_W'(1);
      if (gnt_b_c && (cnt_b_q != {CNT_W{1'b1}})) cnt_b_q <= cnt_b_q + CNT_W'(1);
    end
  end

  assign bus.cnt_a = cnt_a_q;
  assign bus.cnt_b = cnt_b_q;
`else
  assign bus.cnt_a = '0;
  assign bus.cnt_b = '0;
`endif

endmodule
